// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hazard_pkg
// Brief    : Shared types and constants for the pipeline hazard controller.
// Revision : 1.0 - initial release
// ============================================================================
package hazard_pkg;

  // Register-address width of the RV64I register file.
  localparam int REG_AW = 5;

  // E-stage operand source select.
  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  // Sequencer states.
  typedef enum logic [1:0] {
    HZ_INIT     = 2'd0,
    HZ_RUN      = 2'd1,
    HZ_MEM_WAIT = 2'd2
  } hz_state_e;

endpackage
`default_nettype wire

// File: rtl/hazard_fwd_unit.sv
`default_nettype none
// ============================================================================
// Module   : hazard_fwd_unit
// Brief    : Forward-select for one E-stage source operand. M beats W;
//            a write to x0 never forwards.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_fwd_unit
  import hazard_pkg::*;
#(
  parameter int AW = hazard_pkg::REG_AW
) (
  input  logic [AW-1:0] rs_e,
  input  logic [AW-1:0] rd_m,
  input  logic [AW-1:0] rd_w,
  input  logic          reg_write_m,
  input  logic          reg_write_w,
  output logic [1:0]    sel
);

  fwd_sel_e sel_enum;

  // Pick the youngest in-flight producer of rs_e.
  always_comb begin
    sel_enum = FWD_RF;
    if (reg_write_m && (rd_m != '0) && (rd_m == rs_e)) begin
      sel_enum = FWD_MEM;
    end else if (reg_write_w && (rd_w != '0) && (rd_w == rs_e)) begin
      sel_enum = FWD_WB;
    end
  end

  assign sel = sel_enum;

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Brief    : Pipeline sequencer for the 5-stage core: stall/flush controls,
//            E-stage forward selects, data-memory freeze with timeout, and a
//            one-cycle flush after reset release.
//            Optional macro HAZARD_PERF_EN enables saturating perf counters;
//            without it the counter ports are tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW  = hazard_pkg::REG_AW,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] Rs1E,
  input  logic [REG_AW-1:0] Rs2E,
  input  logic [REG_AW-1:0] RdE,
  input  logic [REG_AW-1:0] RdM,
  input  logic [REG_AW-1:0] RdW,
  input  logic              LoadE,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              PCSrcE,
  input  logic              MemReqM,
  input  logic              MemReadyM,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              StallM,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushW,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              MemErr,
  output logic [CNT_W-1:0]  StallCnt,
  output logic [CNT_W-1:0]  FlushCnt,
  output logic [CNT_W-1:0]  WaitCnt
);

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  hz_state_e  state;
  hz_state_e  state_next;
  logic [7:0] wait_cnt;
  logic [7:0] wait_cnt_next;
  logic [7:0] wait_cnt_inc;
  logic       lw_stall;
  logic       freeze;
  logic       timeout_hit;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;

  logic stall_f, stall_d, stall_e, stall_m;
  logic flush_d, flush_e, flush_w, mem_err;

  hazard_fwd_unit #(.AW(REG_AW)) u_fwd_a (
    .rs_e        (Rs1E),
    .rd_m        (RdM),
    .rd_w        (RdW),
    .reg_write_m (RegWriteM),
    .reg_write_w (RegWriteW),
    .sel         (fwd_a)
  );

  hazard_fwd_unit #(.AW(REG_AW)) u_fwd_b (
    .rs_e        (Rs2E),
    .rd_m        (RdM),
    .rd_w        (RdW),
    .reg_write_m (RegWriteM),
    .reg_write_w (RegWriteW),
    .sel         (fwd_b)
  );

  assign lw_stall = LoadE && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));

  // A freeze starts on an unready access in RUN and persists in MEM_WAIT
  // until memory reports ready.
  assign freeze = ((state == HZ_RUN) && MemReqM && !MemReadyM) ||
                  ((state == HZ_MEM_WAIT) && !MemReadyM);

  // wait_cnt holds the number of freeze cycles already completed.
  assign wait_cnt_inc = wait_cnt + 8'd1;
  assign timeout_hit  = freeze && (wait_cnt_inc == TIMEOUT_C);

  // State and wait-counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= HZ_INIT;
      wait_cnt <= 8'd0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
    end
  end

  // Next-state: leave INIT after one cycle, enter/stay in MEM_WAIT while frozen.
  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    case (state)
      HZ_INIT: begin
        state_next    = HZ_RUN;
        wait_cnt_next = 8'd0;
      end
      HZ_RUN, HZ_MEM_WAIT: begin
        if (freeze && !timeout_hit) begin
          state_next    = HZ_MEM_WAIT;
          wait_cnt_next = wait_cnt_inc;
        end else begin
          state_next    = HZ_RUN;
          wait_cnt_next = 8'd0;
        end
      end
      default: begin
        state_next    = HZ_INIT;
        wait_cnt_next = 8'd0;
      end
    endcase
  end

  // Control outputs: freeze beats redirect, redirect beats load-use.
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_w = 1'b0;
    mem_err = 1'b0;
    if (rst_n) begin
      case (state)
        HZ_INIT: begin
          flush_d = 1'b1;
          flush_e = 1'b1;
        end
        HZ_RUN, HZ_MEM_WAIT: begin
          if (freeze) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
            flush_w = 1'b1;
            mem_err = timeout_hit;
          end else if (PCSrcE) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
          end else if (lw_stall) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
          end
        end
        default: begin
          stall_f = 1'b0;
        end
      endcase
    end
  end

  assign StallF    = stall_f;
  assign StallD    = stall_d;
  assign StallE    = stall_e;
  assign StallM    = stall_m;
  assign FlushD    = flush_d;
  assign FlushE    = flush_e;
  assign FlushW    = flush_w;
  assign MemErr    = mem_err;
  assign ForwardAE = rst_n ? fwd_a : 2'b00;
  assign ForwardBE = rst_n ? fwd_b : 2'b00;

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic [CNT_W-1:0] wait_cyc_cnt;

  // Saturating event counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt    <= '0;
      flush_cnt    <= '0;
      wait_cyc_cnt <= '0;
    end else begin
      if ((stall_f || stall_d || stall_e || stall_m) && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if ((flush_d || flush_e) && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
      if ((state == HZ_MEM_WAIT) && (wait_cyc_cnt != '1)) begin
        wait_cyc_cnt <= wait_cyc_cnt + CNT_W'(1);
      end
    end
  end

  assign StallCnt = stall_cnt;
  assign FlushCnt = flush_cnt;
  assign WaitCnt  = wait_cyc_cnt;
`else
  assign StallCnt = '0;
  assign FlushCnt = '0;
  assign WaitCnt  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_ctrl
// Brief    : Self-checking bench for hazard_ctrl (table vectors, directed
//            corner sequences, random stimulus against a reference model).
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

  localparam int TO    = 4;
  localparam int CNT_W = 32;
`ifdef HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic LoadE, RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM;
  logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr;
  logic [1:0] ForwardAE, ForwardBE;
  logic [CNT_W-1:0] StallCnt, FlushCnt, WaitCnt;
  logic [11:0] outs;

  int total = 0;
  int bad   = 0;

  // reference model state
  bit      m_init;
  int      m_run;
  longint  m_sc, m_fc, m_wc;

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_AW(5), .TIMEOUT(TO), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .LoadE(LoadE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .PCSrcE(PCSrcE), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .MemErr(MemErr),
    .StallCnt(StallCnt), .FlushCnt(FlushCnt), .WaitCnt(WaitCnt)
  );

  // {StallF,D,E,M, FlushD,E,W, FwdA, FwdB, MemErr}
  assign outs = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
                 ForwardAE, ForwardBE, MemErr};

  typedef struct {
    logic [4:0]  rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic        loade, rwm, rww, pcs;
    logic [11:0] exp;
  } vec_t;

  task automatic check12(input string name, input logic [11:0] act, input logic [11:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  function automatic logic [1:0] fwd(input logic [4:0] rs);
    if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
    if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [31:0] sat(input longint v);
    return (v > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : v[31:0];
  endfunction

  // One clock: compare DUT with the model before the edge, advance the model after.
  task automatic cycle_check(input string name);
    logic [11:0] e;
    logic [1:0]  fa, fb;
    logic        lw, fz;
    #1;
    if (!rst_n) begin
      m_init = 1; m_run = 0; m_sc = 0; m_fc = 0; m_wc = 0;
    end
    fa = fwd(Rs1E);
    fb = fwd(Rs2E);
    lw = LoadE && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
    fz = (MemReqM || m_run > 0) && !MemReadyM;
    if (!rst_n)        e = 12'b0;
    else if (m_init)   e = {4'b0000, 3'b110, fa, fb, 1'b0};
    else if (fz)       e = {4'b1111, 3'b001, fa, fb, (m_run + 1 == TO)};
    else if (PCSrcE)   e = {4'b0000, 3'b110, fa, fb, 1'b0};
    else if (lw)       e = {4'b1100, 3'b010, fa, fb, 1'b0};
    else               e = {4'b0000, 3'b000, fa, fb, 1'b0};
    check12({name, "_out"}, outs, e);
    check32({name, "_scnt"}, StallCnt, PERF ? sat(m_sc) : 32'd0);
    check32({name, "_fcnt"}, FlushCnt, PERF ? sat(m_fc) : 32'd0);
    check32({name, "_wcnt"}, WaitCnt,  PERF ? sat(m_wc) : 32'd0);
    @(posedge clk);
    if (rst_n) begin
      if (e[11:8] != 0) m_sc++;
      if (e[7] || e[6]) m_fc++;
      if (m_run > 0)    m_wc++;
      if (m_init) begin
        m_init = 0;
        m_run  = 0;
      end else if (fz) begin
        m_run++;
        if (m_run == TO) m_run = 0;
      end else begin
        m_run = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    LoadE = 0; RegWriteM = 0; RegWriteW = 0; PCSrcE = 0;
    MemReqM = 0; MemReadyM = 0;
  endtask

  vec_t tbl[10];

  initial begin
    tbl[0] = '{0, 0, 5, 0, 0, 5, 5, 0, 1, 1, 0, {4'b0000, 3'b000, 2'b10, 2'b00, 1'b0}};
    tbl[1] = '{0, 0, 5, 0, 0, 5, 5, 0, 0, 1, 0, {4'b0000, 3'b000, 2'b01, 2'b00, 1'b0}};
    tbl[2] = '{0, 0, 0, 0, 0, 0, 5, 0, 1, 1, 0, {4'b0000, 3'b000, 2'b00, 2'b00, 1'b0}};
    tbl[3] = '{0, 0, 3, 9, 0, 3, 9, 0, 1, 1, 0, {4'b0000, 3'b000, 2'b10, 2'b01, 1'b0}};
    tbl[4] = '{0, 0, 0, 4, 0, 4, 4, 0, 1, 1, 0, {4'b0000, 3'b000, 2'b00, 2'b10, 1'b0}};
    tbl[5] = '{0, 7, 0, 0, 7, 0, 0, 1, 0, 0, 0, {4'b1100, 3'b010, 2'b00, 2'b00, 1'b0}};
    tbl[6] = '{0, 7, 0, 0, 7, 0, 0, 1, 0, 0, 1, {4'b0000, 3'b110, 2'b00, 2'b00, 1'b0}};
    tbl[7] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, {4'b0000, 3'b000, 2'b00, 2'b00, 1'b0}};
    tbl[8] = '{7, 0, 0, 0, 7, 0, 0, 1, 0, 0, 0, {4'b1100, 3'b010, 2'b00, 2'b00, 1'b0}};
    tbl[9] = '{7, 0, 0, 0, 7, 0, 0, 0, 0, 0, 0, {4'b0000, 3'b000, 2'b00, 2'b00, 1'b0}};

    rst_n = 1'b0;
    idle_inputs();
    m_init = 1; m_run = 0; m_sc = 0; m_fc = 0; m_wc = 0;
    @(negedge clk);
    cycle_check("reset");

    // Reset release: one INIT flush cycle, then quiet.
    rst_n = 1'b1;
    #1 check12("init_flush", outs, {4'b0000, 3'b110, 2'b00, 2'b00, 1'b0});
    cycle_check("init");
    #1 check12("after_init", outs, 12'b0);
    cycle_check("run0");

    // Table vectors, one RUN cycle each.
    for (int i = 0; i < 10; i++) begin
      Rs1D = tbl[i].rs1d; Rs2D = tbl[i].rs2d; Rs1E = tbl[i].rs1e; Rs2E = tbl[i].rs2e;
      RdE = tbl[i].rde; RdM = tbl[i].rdm; RdW = tbl[i].rdw;
      LoadE = tbl[i].loade; RegWriteM = tbl[i].rwm; RegWriteW = tbl[i].rww;
      PCSrcE = tbl[i].pcs;
      #1 check12($sformatf("tbl%0d", i), outs, tbl[i].exp);
      cycle_check($sformatf("tblm%0d", i));
    end
    idle_inputs();

    // Memory wait: three unready cycles then ready.
    MemReqM = 1; MemReadyM = 0;
    for (int i = 0; i < 3; i++) begin
      #1 check12($sformatf("memwait%0d", i), outs, {4'b1111, 3'b001, 2'b00, 2'b00, 1'b0});
      cycle_check("memwait");
    end
    MemReadyM = 1;
    #1 check12("memwait_exit", outs, 12'b0);
    cycle_check("memexit");
    MemReqM = 0; MemReadyM = 0;
    #1 check32("waitcnt3", WaitCnt, PERF ? 32'd3 : 32'd0);
    cycle_check("memidle");

    // Timeout: MemErr only on the fourth frozen cycle.
    MemReqM = 1; MemReadyM = 0;
    for (int i = 0; i < TO; i++) begin
      #1 check12($sformatf("timeout%0d", i), outs,
                 {4'b1111, 3'b001, 2'b00, 2'b00, (i == TO - 1) ? 1'b1 : 1'b0});
      cycle_check("timeout");
    end
    MemReqM = 0;
    #1 check12("timeout_run", outs, 12'b0);
    cycle_check("toidle");

    // Reset asserted mid-wait.
    MemReqM = 1; MemReadyM = 0;
    cycle_check("rwait0");
    cycle_check("rwait1");
    #2 rst_n = 1'b0;
    #1 check12("rst_mid_out", outs, 12'b0);
    check32("rst_mid_cnt", StallCnt, 32'd0);
    cycle_check("rst_low");
    rst_n = 1'b1; MemReqM = 0;
    #1 check12("rst_mid_init", outs, {4'b0000, 3'b110, 2'b00, 2'b00, 1'b0});
    cycle_check("rst_init");

    // Random stimulus against the model.
    for (int n = 0; n < 2000; n++) begin
      Rs1D = 5'($urandom_range(0, 7)); Rs2D = 5'($urandom_range(0, 7));
      Rs1E = 5'($urandom_range(0, 7)); Rs2E = 5'($urandom_range(0, 7));
      RdE  = 5'($urandom_range(0, 7)); RdM  = 5'($urandom_range(0, 7));
      RdW  = 5'($urandom_range(0, 7));
      LoadE     = ($urandom_range(0, 2) == 0);
      RegWriteM = $urandom_range(0, 1) != 0;
      RegWriteW = $urandom_range(0, 1) != 0;
      PCSrcE    = ($urandom_range(0, 4) == 0);
      MemReqM   = ($urandom_range(0, 2) == 0);
      MemReadyM = ($urandom_range(0, 2) == 0);
      rst_n     = ($urandom_range(0, 149) != 0);
      cycle_check("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
